// File: rtl/cache_tag_store.sv
// N-way set-associative tag/valid store with tree pseudo-LRU replacement,
// combinational lookup, victim-selected fills and a one-set-per-cycle flush sweep.
module cache_tag_store #(
  parameter  int unsigned SETS  = 64,
  parameter  int unsigned WAYS  = 2,
  parameter  int unsigned TAG_W = 6,
  localparam int unsigned SET_W = $clog2(SETS),
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lkp_valid,
  input  logic [SET_W-1:0] lkp_set,
  input  logic [TAG_W-1:0] lkp_tag,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  input  logic             fill_valid,
  input  logic [SET_W-1:0] fill_set,
  input  logic [TAG_W-1:0] fill_tag,
  output logic [WAY_W-1:0] victim_way,
  output logic             fill_done,
  output logic [WAY_W-1:0] fill_way,
  input  logic             flush_req,
  output logic             busy
);

  localparam int unsigned NODE_W = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t           r_state, w_state_nxt;
  logic [SET_W-1:0] r_cnt;
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAYS-2:0]  r_plru  [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic             r_fill_done;
  logic [WAY_W-1:0] r_fill_way;

  logic             w_busy, w_hit_any, w_fmatch, w_inv_found, w_fill_acc;
  logic [WAY_W-1:0] w_hit_way, w_fmatch_way, w_inv_way, w_victim, w_fill_wr_way;

  // Walk from the root following each node bit toward the LRU side.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] lru);
    int unsigned n;
    n = 0;
    for (int unsigned l = 0; l < WAY_W; l++)
      n = lru[NODE_W'(n)] ? (2 * n + 2) : (2 * n + 1);
    return WAY_W'(n - (WAYS - 1));
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] lru,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0]  res;
    logic [WAY_W-1:0] sh;
    int unsigned      n;
    res = lru;
    sh  = way;
    n   = 0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      res[NODE_W'(n)] = ~sh[WAY_W-1];
      n  = sh[WAY_W-1] ? (2 * n + 2) : (2 * n + 1);
      sh = sh << 1;
    end
    return res;
  endfunction

  assign w_busy = (r_state == S_SWEEP);

  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (r_valid[lkp_set][WAY_W'(w)] && (r_tag[lkp_set][WAY_W'(w)] == lkp_tag)) begin
        w_hit_any = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    w_fmatch     = 1'b0;
    w_fmatch_way = '0;
    w_inv_found  = 1'b0;
    w_inv_way    = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (r_valid[fill_set][WAY_W'(w)] && (r_tag[fill_set][WAY_W'(w)] == fill_tag)) begin
        w_fmatch     = 1'b1;
        w_fmatch_way = WAY_W'(w);
      end
      if (!w_inv_found && !r_valid[fill_set][WAY_W'(w)]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
  end

  assign w_victim      = w_inv_found ? w_inv_way : plru_victim(r_plru[fill_set]);
  assign w_fill_acc    = fill_valid & ~w_busy;
  // Refilling a resident tag rewrites its way so a set never holds duplicates.
  assign w_fill_wr_way = w_fmatch ? w_fmatch_way : w_victim;

  assign hit        = lkp_valid & ~w_busy & w_hit_any;
  assign hit_way    = hit ? w_hit_way : '0;
  assign victim_way = w_victim;
  assign fill_done  = r_fill_done;
  assign fill_way   = r_fill_way;
  assign busy       = w_busy;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (flush_req) w_state_nxt = S_SWEEP;
      S_SWEEP: if (r_cnt == SET_W'(SETS - 1)) w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fill_done <= 1'b0;
      r_fill_way  <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        r_valid[SET_W'(s)] <= '0;
        r_plru[SET_W'(s)]  <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_fill_done <= w_fill_acc;
      if (w_fill_acc) r_fill_way <= w_fill_wr_way;
      r_cnt <= (r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      if (w_busy) begin
        r_valid[r_cnt] <= '0;
        r_plru[r_cnt]  <= '0;
      end
      // A fill to the looked-up set owns the LRU update for that set.
      if (hit && !(w_fill_acc && (fill_set == lkp_set)))
        r_plru[lkp_set] <= plru_touch(r_plru[lkp_set], w_hit_way);
      if (w_fill_acc) begin
        r_valid[fill_set][w_fill_wr_way] <= 1'b1;
        r_plru[fill_set] <= plru_touch(r_plru[fill_set], w_fill_wr_way);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_acc) r_tag[fill_set][w_fill_wr_way] <= fill_tag;
  end

endmodule

// File: tb/tb_cache_tag_store.sv
// Scoreboarded random/directed bench for cache_tag_store: a 4-way/64-set and a
// 2-way/16-set instance checked against a set/way/PLRU-tree reference model.
module tb_cache_tag_store;

  typedef struct { int cyc; bit hit; int hw; int vw; bit busy; } comb_t;
  typedef struct { int cyc; int way; } fill_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst0, lv0, fv0, fr0, hit0, fd0, busy0;
  logic [5:0] ls0, fs0, lt0, ft0;
  logic [1:0] hw0, vw0, fw0;
  logic       rst1, lv1, fv1, fr1, hit1, fd1, busy1;
  logic [3:0] ls1, fs1;
  logic [5:0] lt1, ft1;
  logic       hw1, vw1, fw1;

  cache_tag_store #(.SETS(64), .WAYS(4), .TAG_W(6)) u_dut4 (
    .clk(clk), .rst(rst0), .lkp_valid(lv0), .lkp_set(ls0), .lkp_tag(lt0),
    .hit(hit0), .hit_way(hw0), .fill_valid(fv0), .fill_set(fs0), .fill_tag(ft0),
    .victim_way(vw0), .fill_done(fd0), .fill_way(fw0), .flush_req(fr0), .busy(busy0));

  cache_tag_store #(.SETS(16), .WAYS(2), .TAG_W(6)) u_dut2 (
    .clk(clk), .rst(rst1), .lkp_valid(lv1), .lkp_set(ls1), .lkp_tag(lt1),
    .hit(hit1), .hit_way(hw1), .fill_valid(fv1), .fill_set(fs1), .fill_tag(ft1),
    .victim_way(vw1), .fill_done(fd1), .fill_way(fw1), .flush_req(fr1), .busy(busy1));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: [dut][set][way] valid/tag, [dut][set][node] PLRU bits.
  bit    mv [2][64][8];
  int    mt [2][64][8];
  bit    mp [2][64][8];
  int    rem [2];
  int    swp [2];
  comb_t qc0[$], qc1[$];
  fill_t qf0[$], qf1[$];

  function automatic int nw(int d); return (d == 0) ? 4 : 2; endfunction
  function automatic int ns(int d); return (d == 0) ? 64 : 16; endfunction

  function automatic void m_clear_set(int d, int s);
    for (int i = 0; i < 8; i++) begin
      mv[d][s][i] = 1'b0;
      mp[d][s][i] = 1'b0;
    end
  endfunction

  function automatic int m_lookup(int d, int s, int t);
    for (int w = 0; w < nw(d); w++)
      if (mv[d][s][w] && mt[d][s][w] == t) return w;
    return -1;
  endfunction

  function automatic int m_victim(int d, int s);
    int n;
    for (int w = 0; w < nw(d); w++)
      if (!mv[d][s][w]) return w;
    n = 0;
    while (n < nw(d) - 1) n = mp[d][s][n] ? (2 * n + 2) : (2 * n + 1);
    return n - (nw(d) - 1);
  endfunction

  // Climb from the leaf; each parent is pointed at the sibling subtree.
  function automatic void m_touch(int d, int s, int w);
    int c, p;
    c = w + nw(d) - 1;
    while (c > 0) begin
      p = (c - 1) / 2;
      mp[d][s][p] = (c == 2 * p + 1);
      c = p;
    end
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(int d, bit r, bit lv, int ls, int lt, bit fv, int fs, int ft, bit fr);
    comb_t ce;
    fill_t fe;
    int    h, fw;
    bit    bz;
    @(posedge clk);
    #1;
    if (d == 0) begin
      rst0 = r; lv0 = lv; ls0 = 6'(ls); lt0 = 6'(lt);
      fv0 = fv; fs0 = 6'(fs); ft0 = 6'(ft); fr0 = fr;
      lv1 = 1'b0; fv1 = 1'b0; fr1 = 1'b0;
    end else begin
      rst1 = r; lv1 = lv; ls1 = 4'(ls); lt1 = 6'(lt);
      fv1 = fv; fs1 = 4'(fs); ft1 = 6'(ft); fr1 = fr;
      lv0 = 1'b0; fv0 = 1'b0; fr0 = 1'b0;
    end
    if (r) begin
      for (int s = 0; s < 64; s++) m_clear_set(d, s);
      rem[d] = 0;
      swp[d] = 0;
      if (d == 0) qf0.delete(); else qf1.delete();
    end
    bz      = (rem[d] > 0);
    h       = (lv && !bz) ? m_lookup(d, ls, lt) : -1;
    ce.cyc  = cyc;
    ce.hit  = (h >= 0);
    ce.hw   = (h >= 0) ? h : 0;
    ce.vw   = m_victim(d, fs);
    ce.busy = bz;
    if (d == 0) qc0.push_back(ce); else qc1.push_back(ce);
    if (!r) begin
      if (bz) begin
        m_clear_set(d, swp[d]);
        swp[d]++;
        rem[d]--;
      end else begin
        if (ce.hit && !(fv && fs == ls)) m_touch(d, ls, ce.hw);
        if (fv) begin
          fw = m_lookup(d, fs, ft);
          if (fw < 0) fw = ce.vw;
          mv[d][fs][fw] = 1'b1;
          mt[d][fs][fw] = ft;
          m_touch(d, fs, fw);
          fe.cyc = cyc + 1;
          fe.way = fw;
          if (d == 0) qf0.push_back(fe); else qf1.push_back(fe);
        end
        if (fr) begin
          rem[d] = ns(d);
          swp[d] = 0;
        end
      end
    end
  endtask

  task automatic idle(int d);            step(d, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic lk(int d, int s, int t); step(d, 0, 1, s, t, 0, s, 0, 0); endtask
  task automatic fl(int d, int s, int t); step(d, 0, 0, 0, 0, 1, s, t, 0); endtask

  always @(negedge clk) begin
    comb_t ce;
    fill_t fe;
    bit    efd;
    if (qc0.size() > 0) begin
      ce = qc0.pop_front();
      chk("hit4", int'(hit0), int'(ce.hit));
      chk("hit_way4", int'(hw0), ce.hw);
      chk("victim4", int'(vw0), ce.vw);
      chk("busy4", int'(busy0), int'(ce.busy));
    end
    while (qf0.size() > 0 && qf0[0].cyc < cyc) void'(qf0.pop_front());
    efd = (qf0.size() > 0 && qf0[0].cyc == cyc);
    chk("fill_done4", int'(fd0), int'(efd));
    if (efd) begin
      fe = qf0.pop_front();
      chk("fill_way4", int'(fw0), fe.way);
    end
    if (qc1.size() > 0) begin
      ce = qc1.pop_front();
      chk("hit2", int'(hit1), int'(ce.hit));
      chk("hit_way2", int'(hw1), ce.hw);
      chk("victim2", int'(vw1), ce.vw);
      chk("busy2", int'(busy1), int'(ce.busy));
    end
    while (qf1.size() > 0 && qf1[0].cyc < cyc) void'(qf1.pop_front());
    efd = (qf1.size() > 0 && qf1[0].cyc == cyc);
    chk("fill_done2", int'(fd1), int'(efd));
    if (efd) begin
      fe = qf1.pop_front();
      chk("fill_way2", int'(fw1), fe.way);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; lv0 = 1'b0; fv0 = 1'b0; fr0 = 1'b0; ls0 = '0; fs0 = '0; lt0 = '0; ft0 = '0;
    rst1 = 1'b1; lv1 = 1'b0; fv1 = 1'b0; fr1 = 1'b0; ls1 = '0; fs1 = '0; lt1 = '0; ft1 = '0;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 64; s++) m_clear_set(d, s);
      rem[d] = 0;
      swp[d] = 0;
    end
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);

    // Basic miss / fill / hit.
    lk(0, 5, 'h2A);
    fl(0, 5, 'h2A);
    idle(0);
    lk(0, 5, 'h2A);

    // Fill a whole set, touch two ways, replace via PLRU.
    for (int t = 1; t <= 4; t++) fl(0, 3, t);
    lk(0, 3, 'h01);
    lk(0, 3, 'h03);
    fl(0, 3, 'h05);
    lk(0, 3, 'h02);
    fl(0, 3, 'h03);
    for (int t = 1; t <= 5; t++) lk(0, 3, t);

    // Same-cycle lookup and fill on one set.
    fl(0, 7, 'h0F);
    fl(0, 7, 'h10);
    step(0, 0, 1, 7, 'h10, 1, 7, 'h11, 0);
    step(0, 0, 1, 7, 'h11, 0, 7, 0, 0);
    for (int t = 'h20; t <= 'h23; t++) fl(0, 8, t);
    step(0, 0, 1, 8, 'h20, 1, 8, 'h24, 0);
    step(0, 0, 1, 8, 'h21, 0, 8, 0, 0);
    step(0, 0, 1, 8, 'h22, 1, 2, 'h30, 0);
    step(0, 0, 0, 0, 0, 0, 8, 0, 0);

    // Full flush with fills, lookups and extra flush requests while busy.
    fl(0, 9, 'h33);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 64; i++) begin
      if (i % 8 == 0)      fl(0, 9, 'h3C);
      else if (i % 8 == 4) lk(0, 9, 'h33);
      else if (i == 30)    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      else                 idle(0);
    end
    lk(0, 5, 'h2A);
    lk(0, 3, 'h03);
    lk(0, 9, 'h33);

    // Flush request coincident with a fill.
    step(0, 0, 0, 0, 0, 1, 10, 'h15, 1);
    for (int i = 0; i < 64; i++) idle(0);
    lk(0, 10, 'h15);

    // Reset in the middle of a sweep.
    fl(0, 5, 'h2A);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) idle(0);
    step(0, 1, 1, 5, 'h2A, 0, 5, 0, 0);
    lk(0, 5, 'h2A);
    fl(0, 5, 'h2A);
    idle(0);
    lk(0, 5, 'h2A);

    // Randomized traffic on a few sets to force conflicts and replacements.
    for (int i = 0; i < 3000; i++)
      step(0, bit'($urandom % 1000 == 0), bit'($urandom % 2), int'($urandom % 4),
           int'($urandom % 8), bit'($urandom % 3 == 0), int'($urandom % 4),
           int'($urandom % 8), bit'($urandom % 400 == 0));
    idle(0);
    idle(0);

    // 2-way / 16-set instance.
    idle(1);
    lk(1, 5, 'h2A);
    fl(1, 5, 'h2A);
    idle(1);
    lk(1, 5, 'h2A);
    fl(1, 5, 'h2B);
    lk(1, 5, 'h2A);
    fl(1, 5, 'h2C);
    lk(1, 5, 'h2B);
    for (int i = 0; i < 800; i++)
      step(1, 1'b0, bit'($urandom % 2), int'($urandom % 2), int'($urandom % 6),
           bit'($urandom % 3 == 0), int'($urandom % 2), int'($urandom % 6),
           bit'($urandom % 200 == 0));
    idle(1);
    idle(1);
    idle(1);
    chk("fill_queue_drain", qf0.size() + qf1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_tag_store.md
Name: cache_tag_store

Overview:
- Parametrised N-way set-associative tag/metadata store for the cache processor; generalises the fixed 64-set, 2-way, 1-bit-LRU tag array.
- Holds a valid bit, tag and tree pseudo-LRU state per set.
- Provides same-cycle hit lookup and victim-selected fills.
- Adds a multi-cycle flush engine that invalidates every set, one set per cycle.

Parameters:
SETS, 64, number of sets (power of 2, >=2); SET_W = log2(SETS)
WAYS, 2, associativity (power of 2, 2..8); WAY_W = log2(WAYS)
TAG_W, 6, tag width in bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
lkp_valid  input  1  lookup request this cycle
lkp_set  input  SET_W  lookup set index (binary)
lkp_tag  input  TAG_W  lookup tag
hit  output  1  lookup hit (combinational)
hit_way  output  WAY_W  way that hit; 0 when hit=0
fill_valid  input  1  install fill_tag into fill_set this cycle
fill_set  input  SET_W  fill set index
fill_tag  input  TAG_W  fill tag
victim_way  output  WAY_W  way a fill to fill_set would write (combinational)
fill_done  output  1  registered one-cycle pulse after an accepted fill
fill_way  output  WAY_W  registered way written by that fill
flush_req  input  1  start invalidate-all sweep
busy  output  1  flush in progress

Behaviour:
- Reset (asynchronous, active-high):
  - Clears all valid bits and all LRU bits.
  - FSM goes to IDLE.
  - fill_done=0, fill_way=0, busy=0.
  - Tag contents are don't-care.
- Lookup:
  - hit = lkp_valid & ~busy & (some way in lkp_set is valid with a matching tag).
  - Same-cycle, combinational on current state.
  - At most one way can match (see fill rule). hit_way is that way's index.
- Touch: on the clock edge with hit=1 and no accepted fill to the same set, the LRU of lkp_set is updated to mark hit_way most-recently-used.
- Tree PLRU, per set:
  - WAYS-1 bits; node i has children 2i+1 and 2i+2; leaves map to ways left to right.
  - Node bit 0 means the victim lies in the left subtree; 1 means the right subtree.
  - Touching way w sets every node on w's path to point away from w.
  - WAYS=2 reduces to one bit: 0 means way0 is LRU.
- Victim selection: the lowest-index invalid way in fill_set, if any; otherwise the way reached by walking the tree from the root.
- Fill, accepted when fill_valid & ~busy:
  - If fill_tag already matches a valid way in fill_set, that way is rewritten (no duplicate).
  - Otherwise victim_way is written.
  - The written way gets valid=1 and tag=fill_tag, and becomes MRU in the LRU.
  - Next cycle: fill_done=1 and fill_way = the written way.
- Lookup and fill in the same cycle:
  - Lookup sees pre-fill state.
  - If the sets are equal, only the fill's LRU update is applied.
  - If the sets differ, both updates are applied.
- Flush FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on flush_req; the counter loads 0.
  - In SWEEP, each cycle clears valid and LRU of set[counter], then counter+1.
  - On the last set (SETS-1), SWEEP -> IDLE. Total SETS cycles.
  - busy=1 for exactly the SETS cycles in SWEEP.
  - During busy: hit=0, fills are ignored (no fill_done), and flush_req is ignored.
  - flush_req together with fill_valid in IDLE: the fill is accepted that cycle and the flush starts next cycle. The flushed set later clears it.
- Reset mid-flush: asynchronous abort to IDLE; all state cleared.
- fill_done is never asserted for an ignored fill. The fill_done pulse is never stretched.

Test Plan (WAYS=4, SETS=64, TAG_W=6 unless noted):
- Reset then lookup set 5 tag 0x2A -> hit=0. Fill set 5 tag 0x2A -> victim_way=0, next cycle fill_done=1, fill_way=0. Lookup -> hit=1, hit_way=0.
- Fill set 3 with tags 0x01..0x04 -> ways 0,1,2,3. Touch 0x01 and 0x03, then fill 0x05 -> PLRU victim way1. Afterwards lookup 0x02 -> hit=0.
- Refill an existing tag, set 3 tag 0x03 -> fill_way=2, no duplicate, and 0x03 is the only hit.
- Same cycle: lookup set 7 tag 0x10 (hit, way1) plus fill set 7 tag 0x11 -> hit=1 that cycle, and the LRU reflects only the fill's way as MRU.
- flush_req -> busy=1 for exactly 64 cycles. A fill during busy gives no fill_done. A lookup during busy gives hit=0. After busy falls, all earlier tags miss.
- Assert rst at flush cycle 20 -> busy=0 immediately, all lookups miss, and a fill after release works normally. Repeat the first scenario with WAYS=2, SETS=16.
